fir_cfg_sequencer: RTL and testbench

Control sequencer between the pin-level interface and the FIR datapath. It synchronises the asynchronous sample and config strobes from the pins and turns them into single-cycle sample valids. It runs the coefficient reload protocol: collect taps into a shadow bank, verify an XOR checksum, commit to the filter's coefficient port, then flush the filter. It also blocks samples from the datapath while a reload is in progress.

---
 rtl/fir_pkg.sv | 20 ++
 rtl/fir_edge_sync.sv | 33 +++
 rtl/fir_cfg_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_fir_cfg_sequencer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared types and sizing constants for the FIR configuration sequencer and datapath.
package fir_pkg;

   localparam int NUM_TAPS = 4;
   localparam int COEFF_W  = 8;
   localparam int TAP_AW   = 2;

   // Tap index is one bit wider than the address so it can reach NUM_TAPS.
   localparam logic [TAP_AW:0] IDX_LAST = (TAP_AW + 1)'(NUM_TAPS - 1);
   localparam logic [TAP_AW:0] IDX_ONE  = (TAP_AW + 1)'(1);

   typedef enum logic [2:0] {
      ST_RUN,
      ST_LOAD,
      ST_CHECK,
      ST_COMMIT,
      ST_FLUSH
   } fir_cfg_state_t;

endpackage

// File: rtl/fir_edge_sync.sv
// Multi-flop synchroniser for an asynchronous pin, followed by a registered rising-edge detector.
module fir_edge_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic async_i,
   output logic level_o,
   output logic edge_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic                   edge_q;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
         edge_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
         prev_q <= sync_q[SYNC_STAGES-1];
         edge_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
      end
   end

   // The delayed level lines up with edge_o: whenever edge_o is high, level_o is high too.
   assign level_o = prev_q;
   assign edge_o  = edge_q;

endmodule

// File: rtl/fir_cfg_sequencer.sv
// Pin-to-datapath control: strobe synchronisation, sample forwarding and the checksummed coefficient reload.
module fir_cfg_sequencer
   import fir_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int FIR_LATENCY = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [COEFF_W-1:0] pin_data,
   input  logic               pin_valid,
   input  logic               pin_set_coeffs,
   output logic [COEFF_W-1:0] fir_tdata,
   output logic               fir_tvalid,
   output logic               coeff_we,
   output logic [TAP_AW-1:0]  coeff_addr,
   output logic [COEFF_W-1:0] coeff_wdata,
   output logic               fir_clear,
   output logic               out_valid,
   output logic               busy,
   output logic               cfg_err,
   output logic               sample_drop
);

   logic val_edge;
   logic val_level;
   logic set_edge;
   logic set_level;

   fir_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_val_sync (
      .clk     (clk),
      .rst_n   (rst_n),
      .async_i (pin_valid),
      .level_o (val_level),
      .edge_o  (val_edge)
   );

   fir_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_set_sync (
      .clk     (clk),
      .rst_n   (rst_n),
      .async_i (pin_set_coeffs),
      .level_o (set_level),
      .edge_o  (set_edge)
   );

   fir_cfg_state_t     state_q, state_d;
   logic [TAP_AW:0]    idx_q, idx_d;
   logic [COEFF_W-1:0] csum_q, csum_d;
   logic [COEFF_W-1:0] shadow_q [NUM_TAPS];
   logic [COEFF_W-1:0] shadow_d [NUM_TAPS];

   logic [COEFF_W-1:0] fir_tdata_q, fir_tdata_d;
   logic               fir_tvalid_q, fir_tvalid_d;
   logic               coeff_we_q, coeff_we_d;
   logic [TAP_AW-1:0]  coeff_addr_q, coeff_addr_d;
   logic [COEFF_W-1:0] coeff_wdata_q, coeff_wdata_d;
   logic               fir_clear_q, fir_clear_d;
   logic               cfg_err_q, cfg_err_d;
   logic               sample_drop_q, sample_drop_d;
   logic [FIR_LATENCY-1:0] ovalid_q;

   always_comb begin
      // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
      state_d       = state_q;
      idx_d         = idx_q;
      csum_d        = csum_q;
      shadow_d      = shadow_q;
      fir_tdata_d   = fir_tdata_q;
      fir_tvalid_d  = 1'b0;
      coeff_we_d    = 1'b0;
      coeff_addr_d  = coeff_addr_q;
      coeff_wdata_d = coeff_wdata_q;
      fir_clear_d   = 1'b0;
      cfg_err_d     = cfg_err_q;
      sample_drop_d = 1'b0;

      unique case (state_q)
         ST_RUN: begin
            if (val_edge) begin
               fir_tdata_d  = pin_data;
               fir_tvalid_d = 1'b1;
            end
            if (set_edge) begin
               state_d   = ST_LOAD;
               idx_d     = '0;
               csum_d    = '0;
               cfg_err_d = 1'b0;
            end
         end

         ST_LOAD: begin
            if (!set_level) begin
               cfg_err_d = 1'b1;
               state_d   = ST_RUN;
            end else if (val_edge) begin
               shadow_d[idx_q[TAP_AW-1:0]] = pin_data;
               csum_d = csum_q ^ pin_data;
               idx_d  = idx_q + IDX_ONE;
               if (idx_q == IDX_LAST) state_d = ST_CHECK;
            end
         end

         ST_CHECK: begin
            if (!set_level) begin
               cfg_err_d = 1'b1;
               state_d   = ST_RUN;
            end else if (val_edge) begin
               if (pin_data == csum_q) begin
                  state_d = ST_COMMIT;
                  idx_d   = '0;
               end else begin
                  cfg_err_d = 1'b1;
                  state_d   = ST_RUN;
               end
            end
         end

         // The commit runs to completion regardless of the reload request level.
         ST_COMMIT: begin
            coeff_we_d    = 1'b1;
            coeff_addr_d  = idx_q[TAP_AW-1:0];
            coeff_wdata_d = shadow_q[idx_q[TAP_AW-1:0]];
            idx_d         = idx_q + IDX_ONE;
            if (idx_q == IDX_LAST) state_d = ST_FLUSH;
            sample_drop_d = val_edge;
         end

         ST_FLUSH: begin
            fir_clear_d   = 1'b1;
            state_d       = ST_RUN;
            sample_drop_d = val_edge;
         end

         default: state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_RUN;
         idx_q         <= '0;
         csum_q        <= '0;
         fir_tdata_q   <= '0;
         fir_tvalid_q  <= 1'b0;
         coeff_we_q    <= 1'b0;
         coeff_addr_q  <= '0;
         coeff_wdata_q <= '0;
         fir_clear_q   <= 1'b0;
         cfg_err_q     <= 1'b0;
         sample_drop_q <= 1'b0;
         ovalid_q      <= '0;
         // NOTE: the shadow bank is only NUM_TAPS bytes, so it is reset with the rest of the state.
         for (int i = 0; i < NUM_TAPS; i++) shadow_q[i] <= '0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         csum_q        <= csum_d;
         fir_tdata_q   <= fir_tdata_d;
         fir_tvalid_q  <= fir_tvalid_d;
         coeff_we_q    <= coeff_we_d;
         coeff_addr_q  <= coeff_addr_d;
         coeff_wdata_q <= coeff_wdata_d;
         fir_clear_q   <= fir_clear_d;
         cfg_err_q     <= cfg_err_d;
         sample_drop_q <= sample_drop_d;
         ovalid_q      <= (ovalid_q << 1) | FIR_LATENCY'(fir_tvalid_q);
         for (int i = 0; i < NUM_TAPS; i++) shadow_q[i] <= shadow_d[i];
      end
   end

   // The sync level is only needed for abort detection; the pin_valid level itself is unused.
   logic unused_val_level;
   assign unused_val_level = val_level;

   assign fir_tdata   = fir_tdata_q;
   assign fir_tvalid  = fir_tvalid_q;
   assign coeff_we    = coeff_we_q;
   assign coeff_addr  = coeff_addr_q;
   assign coeff_wdata = coeff_wdata_q;
   assign fir_clear   = fir_clear_q;
   assign out_valid   = ovalid_q[FIR_LATENCY-1];
   assign busy        = (state_q != ST_RUN);
   assign cfg_err     = cfg_err_q;
   assign sample_drop = sample_drop_q;

endmodule

// File: tb/tb_fir_cfg_sequencer.sv
// Scoreboard bench for fir_cfg_sequencer: stimulus pushes expected output events, a monitor pops and compares.
module tb_fir_cfg_sequencer;
   import fir_pkg::*;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic [COEFF_W-1:0] pin_data = '0;
   logic               pin_valid = 1'b0;
   logic               pin_set_coeffs = 1'b0;
   logic [COEFF_W-1:0] fir_tdata;
   logic               fir_tvalid;
   logic               coeff_we;
   logic [TAP_AW-1:0]  coeff_addr;
   logic [COEFF_W-1:0] coeff_wdata;
   logic               fir_clear;
   logic               out_valid;
   logic               busy;
   logic               cfg_err;
   logic               sample_drop;

   fir_cfg_sequencer #(.SYNC_STAGES(2), .FIR_LATENCY(2)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .pin_data       (pin_data),
      .pin_valid      (pin_valid),
      .pin_set_coeffs (pin_set_coeffs),
      .fir_tdata      (fir_tdata),
      .fir_tvalid     (fir_tvalid),
      .coeff_we       (coeff_we),
      .coeff_addr     (coeff_addr),
      .coeff_wdata    (coeff_wdata),
      .fir_clear      (fir_clear),
      .out_valid      (out_valid),
      .busy           (busy),
      .cfg_err        (cfg_err),
      .sample_drop    (sample_drop)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { logic [COEFF_W-1:0] data; int at; } samp_exp_t;
   typedef struct { logic [TAP_AW-1:0] addr; logic [COEFF_W-1:0] data; } coef_exp_t;

   samp_exp_t q_tdata[$];
   int        q_ovalid[$];
   coef_exp_t q_coeff[$];
   int        q_drop[$];
   int        q_clear[$];

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic unexpected(input string name);
      n_vec++;
      n_err++;
      $display("FAIL %s: unexpected pulse, got 1 required 0 (cycle %0d)", name, cyc);
   endtask

   // Monitor: every output strobe consumes one expected entry of its own kind.
   samp_exp_t se;
   coef_exp_t ce;
   int        at;
   always @(negedge clk) begin
      if (rst_n) begin
         if (fir_tvalid) begin
            if (q_tdata.size() == 0) unexpected("fir_tvalid");
            else begin
               se = q_tdata.pop_front();
               check("fir_tdata", fir_tdata, se.data);
               check("fir_tvalid_cycle", cyc, se.at);
            end
         end
         if (out_valid) begin
            if (q_ovalid.size() == 0) unexpected("out_valid");
            else begin
               at = q_ovalid.pop_front();
               check("out_valid_cycle", cyc, at);
            end
         end
         if (coeff_we) begin
            if (q_coeff.size() == 0) unexpected("coeff_we");
            else begin
               ce = q_coeff.pop_front();
               check("coeff_addr", coeff_addr, ce.addr);
               check("coeff_wdata", coeff_wdata, ce.data);
            end
         end
         if (sample_drop) begin
            if (q_drop.size() == 0) unexpected("sample_drop");
            else begin
               at = q_drop.pop_front();
               check("sample_drop_cycle", cyc, at);
            end
         end
         if (fir_clear) begin
            if (q_clear.size() == 0) unexpected("fir_clear");
            else void'(q_clear.pop_front());
         end
      end
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One pin_valid pulse; when fwd is set the byte is expected on the filter port 4 cycles after the rise.
   task automatic pulse_byte(input logic [COEFF_W-1:0] b, input bit fwd);
      @(negedge clk);
      pin_data  = b;
      pin_valid = 1'b1;
      if (fwd) begin
         q_tdata.push_back('{data: b, at: cyc + 4});
         q_ovalid.push_back(cyc + 6);
      end
      wait_cyc(6);
      pin_valid = 1'b0;
      wait_cyc(6);
   endtask

   task automatic expect_commit(input logic [COEFF_W-1:0] t0, t1, t2, t3);
      q_coeff.push_back('{addr: 2'd0, data: t0});
      q_coeff.push_back('{addr: 2'd1, data: t1});
      q_coeff.push_back('{addr: 2'd2, data: t2});
      q_coeff.push_back('{addr: 2'd3, data: t3});
      q_clear.push_back(0);
   endtask

   task automatic load_taps(input logic [COEFF_W-1:0] t0, t1, t2, t3);
      @(negedge clk);
      pin_set_coeffs = 1'b1;
      wait_cyc(6);
      pulse_byte(t0, 1'b0);
      pulse_byte(t1, 1'b0);
      pulse_byte(t2, 1'b0);
      pulse_byte(t3, 1'b0);
   endtask

   // Checksum byte, then a second rise that lands mid-commit and must be dropped.
   task automatic cksum_with_drop(input logic [COEFF_W-1:0] cks);
      @(negedge clk);
      pin_data  = cks;
      pin_valid = 1'b1;
      @(negedge clk);
      pin_valid = 1'b0;
      wait_cyc(2);
      pin_valid = 1'b1;
      q_drop.push_back(cyc + 4);
      wait_cyc(6);
      pin_valid = 1'b0;
      wait_cyc(6);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      wait_cyc(3);
      check("reset_outputs",
            {fir_tdata, fir_tvalid, coeff_we, coeff_addr, coeff_wdata, fir_clear, out_valid, sample_drop}, '0);
      check("reset_busy", busy, 0);
      check("reset_cfg_err", cfg_err, 0);
      rst_n = 1'b1;
      wait_cyc(4);

      // Plain sample forwarding in RUN.
      pulse_byte(8'h5A, 1'b1);
      check("run_busy", busy, 0);

      // Good reload.
      load_taps(8'h01, 8'h02, 8'h04, 8'h08);
      check("load_busy", busy, 1);
      expect_commit(8'h01, 8'h02, 8'h04, 8'h08);
      pulse_byte(8'h0F, 1'b0);
      check("good_busy", busy, 0);
      check("good_cfg_err", cfg_err, 0);
      pin_set_coeffs = 1'b0;
      wait_cyc(6);

      // Bad checksum: no commit, sticky error until the next reload request.
      load_taps(8'h01, 8'h02, 8'h04, 8'h08);
      pulse_byte(8'h0E, 1'b0);
      check("badcks_cfg_err", cfg_err, 1);
      check("badcks_busy", busy, 0);
      pin_set_coeffs = 1'b0;
      wait_cyc(10);
      check("badcks_sticky", cfg_err, 1);

      // Abort after two taps; the new request itself clears the old error.
      @(negedge clk);
      pin_set_coeffs = 1'b1;
      wait_cyc(6);
      check("newreq_cfg_err_clr", cfg_err, 0);
      pulse_byte(8'h11, 1'b0);
      pulse_byte(8'h22, 1'b0);
      pin_set_coeffs = 1'b0;
      wait_cyc(6);
      check("abort_cfg_err", cfg_err, 1);
      check("abort_busy", busy, 0);
      pulse_byte(8'h33, 1'b1);

      // Sample during commit is dropped; a held request does not retrigger after FLUSH.
      load_taps(8'h01, 8'h02, 8'h04, 8'h08);
      expect_commit(8'h01, 8'h02, 8'h04, 8'h08);
      cksum_with_drop(8'h0F);
      wait_cyc(20);
      check("held_busy", busy, 0);
      check("held_cfg_err", cfg_err, 0);
      pulse_byte(8'hC3, 1'b1);
      check("held_busy_after_sample", busy, 0);
      pin_set_coeffs = 1'b0;
      wait_cyc(6);

      // Reset in the middle of LOAD, then a fresh reload.
      load_taps(8'hAA, 8'hBB, 8'hCC, 8'hDD);
      @(negedge clk);
      pin_set_coeffs = 1'b1;
      rst_n = 1'b0;
      #1;
      check("midreset_outputs",
            {fir_tdata, fir_tvalid, coeff_we, coeff_addr, coeff_wdata, fir_clear, out_valid, sample_drop}, '0);
      check("midreset_busy", busy, 0);
      check("midreset_cfg_err", cfg_err, 0);
      pin_set_coeffs = 1'b0;
      wait_cyc(3);
      rst_n = 1'b1;
      wait_cyc(8);
      check("postreset_busy", busy, 0);
      load_taps(8'h10, 8'h20, 8'h30, 8'h40);
      expect_commit(8'h10, 8'h20, 8'h30, 8'h40);
      pulse_byte(8'h40, 1'b0);
      check("fresh_busy", busy, 0);
      check("fresh_cfg_err", cfg_err, 0);
      pin_set_coeffs = 1'b0;
      wait_cyc(6);
      pulse_byte(8'h7E, 1'b1);
      wait_cyc(10);

      check("left_tdata", q_tdata.size(), 0);
      check("left_ovalid", q_ovalid.size(), 0);
      check("left_coeff", q_coeff.size(), 0);
      check("left_drop", q_drop.size(), 0);
      check("left_clear", q_clear.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
